cmd_proc_engine: RTL and testbench

Parametrised command-driven load/process/write engine, the next-generation command FSM for the control-flow test suite. Accepts commands over a valid/ready handshake, loads a DATA_W-bit operand, increments it a per-command iteration count, then presents the result over a valid/ready output port. Timeout, overflow and illegal-command faults are reported through a sticky error with an encoded cause, held until software clears it.

---
 rtl/cmd_proc_engine.sv | 153 +++++++++++++++
 tb/tb_cmd_proc_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_proc_engine.sv
// cmd_proc_engine: command-driven load/process/write engine.
// A command loads an operand (LOAD) or reuses the retained buffer (PROC),
// increments it a per-command number of times, then offers the result on
// an output port. Timeout, overflow and illegal commands park the engine in
// a sticky ERROR state with an encoded cause until clr_err is seen.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. cmd_valid/cmd_ready transfer cmd+iter (ready only in IDLE);
// out_valid/out_ready transfer data_out (valid only in WRITE, data stable
// while waiting); data_valid has no ready and is consumed only in READ.
module cmd_proc_engine #(
  parameter int DATA_W  = 16,
  parameter int ITER_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ITER_W-1:0] iter,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              error_out,
  output logic [1:0]        err_code,
  input  logic              clr_err,
  output logic [2:0]        dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_PROC  = 3'b010;
  localparam logic [2:0] CMD_CLEAR = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERFLW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_PROCESS = 3'd2,
    S_WRITE   = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   buffer_q, buffer_d;
  logic [ITER_W-1:0]   iter_lat_q, iter_lat_d;
  logic [ITER_W-1:0]   done_cnt_q, done_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]          err_code_q, err_code_d;

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buffer_q   <= '0;
      iter_lat_q <= '0;
      done_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      buffer_q   <= buffer_d;
      iter_lat_q <= iter_lat_d;
      done_cnt_q <= done_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and datapath update; every register holds unless changed.
  always_comb begin
    state_d    = state_q;
    buffer_d   = buffer_q;
    iter_lat_d = iter_lat_q;
    done_cnt_d = done_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          iter_lat_d = iter;
          done_cnt_d = '0;
          case (cmd)
            CMD_LOAD: begin
              state_d    = S_READ;
              wait_cnt_d = '0;
            end
            CMD_PROC:  state_d  = S_PROCESS;
            CMD_CLEAR: buffer_d = '0;
            default: begin
              state_d    = S_ERROR;
              err_code_d = ERR_ILLEGAL;
            end
          endcase
        end
      end
      S_READ: begin
        // Arriving data beats the timeout when both happen on one edge.
        if (data_valid) begin
          buffer_d = data_in;
          state_d  = S_PROCESS;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_PROCESS: begin
        // Overflow is reported instead of wrapping; buffer keeps all-ones.
        if (done_cnt_q == iter_lat_q) begin
          state_d = S_WRITE;
        end else if (&buffer_q) begin
          state_d    = S_ERROR;
          err_code_d = ERR_OVERFLW;
        end else begin
          buffer_d   = buffer_q + DATA_W'(1);
          done_cnt_d = done_cnt_q + ITER_W'(1);
        end
      end
      S_WRITE: begin
        if (out_ready) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clr_err) begin
          state_d    = S_IDLE;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only.
  assign cmd_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_WRITE);
  assign data_out  = (state_q == S_WRITE) ? buffer_q : '0;
  assign busy      = (state_q == S_READ) || (state_q == S_PROCESS) ||
                     (state_q == S_WRITE);
  assign error_out = (state_q == S_ERROR);
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cmd_proc_engine.sv
// Directed bench for cmd_proc_engine. Each driver task derives the expected
// per-cycle outputs from the command rules (phase lengths, sum, overflow
// point) and queues them; a compare process checks one entry per cycle.
module tb_cmd_proc_engine;

  localparam int DATA_W  = 16;
  localparam int ITER_W  = 4;
  localparam int TIMEOUT = 8;
  localparam int MAXV    = 65535;

  logic              clk;
  logic              rst_n;
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ITER_W-1:0] iter;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              error_out;
  logic [1:0]        err_code;
  logic              clr_err;
  logic [2:0]        dbg_state;

  cmd_proc_engine #(.DATA_W(DATA_W), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .iter(iter), .data_in(data_in),
    .data_valid(data_valid), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .error_out(error_out),
    .err_code(err_code), .clr_err(clr_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Expected vector: {cmd_ready, busy, out_valid, error_out, err_code, data_out}
  logic [21:0] exp_q[$];
  logic [21:0] cmp_e, cmp_act;
  int checks = 0;
  int errors = 0;

  int          m_buf;     // model of the retained operand buffer
  int          cyc_n = 0;
  int          acc_cyc;
  int          ov_cyc, err_cyc;
  logic        seen_ov, seen_err;
  logic [15:0] ov_data;

  function automatic logic [21:0] e_idle();
    return {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000};
  endfunction
  function automatic logic [21:0] e_busy();
    return {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
  endfunction
  function automatic logic [21:0] e_write(input logic [15:0] d);
    return {1'b0, 1'b1, 1'b1, 1'b0, 2'd0, d};
  endfunction
  function automatic logic [21:0] e_err(input logic [1:0] c);
    return {1'b0, 1'b0, 1'b0, 1'b1, c, 16'h0000};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e   = exp_q.pop_front();
      cmp_act = {cmd_ready, busy, out_valid, error_out, err_code, data_out};
      checks++;
      if (cmp_act !== cmp_e) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, cmp_act, cmp_e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge; queue what the outputs must be after it.
  task automatic cyc(input logic [21:0] e);
    @(posedge clk);
    #1;
    cyc_n++;
    exp_q.push_back(e);
    if (out_valid && !seen_ov) begin
      seen_ov = 1'b1; ov_cyc = cyc_n; ov_data = data_out;
    end
    if (error_out && !seen_err) begin
      seen_err = 1'b1; err_cyc = cyc_n;
    end
  endtask

  task automatic mark_accept();
    acc_cyc  = cyc_n + 1;
    seen_ov  = 1'b0;
    seen_err = 1'b0;
  endtask

  // From PROCESS entry: n increments then WRITE, unless the sum passes MAXV.
  task automatic run_process(input int n, input int w);
    if (m_buf + n > MAXV) begin
      repeat (MAXV - m_buf) cyc(e_busy());
      m_buf = MAXV;
      cyc(e_err(2'd3));
    end else begin
      repeat (n) cyc(e_busy());
      m_buf = m_buf + n;
      cyc(e_write(16'(m_buf)));
      for (int j = 0; j < w; j++) begin
        out_ready  = 1'b0;
        cmd_valid  = 1'b1;
        cmd        = 3'b001;
        data_valid = 1'b1;
        data_in    = 16'($urandom_range(0, 65535));
        cyc(e_write(16'(m_buf)));
      end
      cmd_valid  = 1'b0;
      data_valid = 1'b0;
      out_ready  = 1'b1;
      cyc(e_idle());
      out_ready  = 1'b0;
    end
  endtask

  // LOAD with data presented in READ cycle k (k >= TIMEOUT: never).
  task automatic run_load(input logic [15:0] d, input int n, input int k, input int w);
    logic timed_out;
    timed_out = 1'b0;
    mark_accept();
    cmd = 3'b001; iter = ITER_W'(n); cmd_valid = 1'b1;
    cyc(e_busy());
    cmd_valid = 1'b0; cmd = 3'b000;
    for (int i = 0; i < TIMEOUT; i++) begin
      data_valid = (i == k);
      data_in    = (i == k) ? d : 16'($urandom_range(0, 65535));
      if (i == k) begin
        cyc(e_busy());
        break;
      end else if (i == TIMEOUT - 1) begin
        cyc(e_err(2'd2));
        timed_out = 1'b1;
      end else begin
        cyc(e_busy());
      end
    end
    data_valid = 1'b0;
    if (!timed_out) begin
      m_buf = int'(d);
      run_process(n, w);
    end
  endtask

  task automatic run_proc(input int n, input int w);
    mark_accept();
    cmd = 3'b010; iter = ITER_W'(n); cmd_valid = 1'b1;
    cyc(e_busy());
    cmd_valid = 1'b0; cmd = 3'b000;
    run_process(n, w);
  endtask

  task automatic run_clear();
    cmd = 3'b100; cmd_valid = 1'b1;
    cyc(e_idle());
    cmd_valid = 1'b0; cmd = 3'b000;
    m_buf = 0;
  endtask

  task automatic run_illegal(input logic [2:0] c);
    cmd = c; cmd_valid = 1'b1;
    cyc(e_err(2'd1));
    cmd_valid = 1'b0; cmd = 3'b000;
  endtask

  // Hold ERROR for e cycles with clr_err low, then clear.
  task automatic clear_err(input int e, input logic [1:0] c);
    clr_err = 1'b0;
    repeat (e) cyc(e_err(c));
    clr_err = 1'b1;
    cyc(e_idle());
    clr_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; cmd = 3'b000; cmd_valid = 1'b0; iter = '0;
    data_in = '0; data_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    m_buf = 0; seen_ov = 1'b0; seen_err = 1'b0;
    ov_cyc = 0; err_cyc = 0; acc_cyc = 0; ov_data = '0;

    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_error_out", 32'(error_out), 32'd0);
    chk("rst_err_code",  32'(err_code),  32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LOAD 0x0100, 5 increments, data in first READ cycle.
    run_load(16'h0100, 5, 0, 0);
    chk("load5_latency", 32'(ov_cyc - acc_cyc + 1), 32'd8);
    chk("load5_data",    32'(ov_data), 32'h0105);

    // Timeout: data never arrives.
    run_load(16'h1234, 2, TIMEOUT, 0);
    chk("timeout_cycles", 32'(err_cyc - acc_cyc), 32'd8);
    clear_err(2, 2'd2);

    // Data on the last allowed READ cycle: no timeout.
    run_load(16'h0040, 1, TIMEOUT - 1, 0);
    chk("late_data", 32'(ov_data), 32'h0041);

    // Overflow: one increment to FFFF then ERROR; buffer retained.
    run_load(16'hFFFE, 3, 0, 0);
    chk("ovf_seen", 32'(seen_err), 32'd1);
    clear_err(0, 2'd3);
    run_proc(0, 0);
    chk("ovf_buffer_kept", 32'(ov_data), 32'hFFFF);

    // Illegal commands.
    run_illegal(3'b111);
    clear_err(1, 2'd1);
    run_illegal(3'b000);
    clear_err(0, 2'd1);

    // CLEAR then PROC iter=0, then PROC reusing the retained buffer.
    run_clear();
    run_proc(0, 0);
    chk("clear_proc0", 32'(ov_data), 32'h0000);
    run_proc(4, 0);
    chk("proc4_latency", 32'(ov_cyc - acc_cyc + 1), 32'd6);
    chk("proc4_data",    32'(ov_data), 32'h0004);
    run_proc(3, 0);
    chk("proc_reuse", 32'(ov_data), 32'h0007);

    // WRITE stalled 4 cycles with cmd_valid/data_valid pushed meanwhile.
    run_load(16'h0A00, 2, 1, 4);
    chk("stall_data", 32'(ov_data), 32'h0A02);
    run_proc(15, 0);
    chk("iter_max", 32'(ov_data), 32'h0A11);

    // clr_err outside ERROR has no effect.
    clr_err = 1'b1;
    cyc(e_idle());
    clr_err = 1'b0;

    // Reset asserted asynchronously in the middle of PROCESS.
    cmd = 3'b001; iter = 4'd10; cmd_valid = 1'b1;
    cyc(e_busy());
    cmd_valid = 1'b0; data_in = 16'h0200; data_valid = 1'b1;
    cyc(e_busy());
    data_valid = 1'b0;
    cyc(e_busy());
    cyc(e_busy());
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data_out",  32'(data_out),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_buf = 0;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    run_proc(0, 0);
    chk("post_rst_buffer", 32'(ov_data), 32'h0000);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
